// File: rtl/image_morph_if.sv
// Handshake and frame bus for image_morph_engine. The passes field exists only
// when IMAGE_MORPH_MULTIPASS_EN is defined.
interface image_morph_if #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  logic                   start;
  logic [1:0]             mode;
  logic [IMG_W*IMG_H-1:0] in_image;
`ifdef IMAGE_MORPH_MULTIPASS_EN
  logic [1:0]             passes;
`endif
  logic                   busy;
  logic                   done;
  logic [IMG_W*IMG_H-1:0] out_image;
  logic [IMG_W*IMG_H-1:0] show_image;

`ifdef IMAGE_MORPH_MULTIPASS_EN
  modport master (output start, mode, in_image, passes,
                  input  busy, done, out_image, show_image);
  modport slave  (input  start, mode, in_image, passes,
                  output busy, done, out_image, show_image);
`else
  modport master (output start, mode, in_image,
                  input  busy, done, out_image, show_image);
  modport slave  (input  start, mode, in_image,
                  output busy, done, out_image, show_image);
`endif
endinterface

// File: rtl/image_morph_engine.sv
// Row-serial binary morphology (dilate / erode / pass) over a latched frame.
// Define IMAGE_MORPH_MULTIPASS_EN to add the passes input (1..4 repeated passes).
module image_morph_engine #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int RADIUS = 1
) (
  input  logic         clk,
  input  logic         rst,
  image_morph_if.slave bus
);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
  typedef logic [IMG_H-1:0][IMG_W-1:0] frame_t;

  state_t           state, state_nxt;
  frame_t           frame, work, work_nxt;
  logic [ROW_W-1:0] row;
  logic [1:0]       mode_q;
  logic [IMG_W-1:0] row_res;
  logic [NPIX-1:0]  out_q, show_q;
  logic             last_row, last_pass;

`ifdef IMAGE_MORPH_MULTIPASS_EN
  logic [1:0] passes_q, pass_cnt;
  assign last_pass = (pass_cnt == passes_q);
`else
  assign last_pass = 1'b1;
`endif

  assign last_row = (row == LAST_ROW);

  // Out-of-frame neighbours read as 0, which also clears eroded borders.
  function automatic logic pix(input frame_t f, input int y, input int x);
    if (y < 0 || y >= IMG_H || x < 0 || x >= IMG_W) return 1'b0;
    return f[ROW_W'(y)][COL_W'(x)];
  endfunction

  function automatic logic [NPIX-1:0] bit_rev(input frame_t f);
    logic [NPIX-1:0] flat;
    logic [NPIX-1:0] r;
    flat = f;
    r    = '0;
    for (int i = 0; i < NPIX; i++) r[NPIX-1-i] = flat[i];
    return r;
  endfunction

  always_comb begin
    logic acc_or, acc_and, p;
    row_res = '0;
    acc_or  = 1'b0;
    acc_and = 1'b1;
    p       = 1'b0;
    for (int x = 0; x < IMG_W; x++) begin
      acc_or  = 1'b0;
      acc_and = 1'b1;
      for (int dy = -RADIUS; dy <= RADIUS; dy++) begin
        for (int dx = -RADIUS; dx <= RADIUS; dx++) begin
          p       = pix(frame, int'(row) + dy, x + dx);
          acc_or  = acc_or | p;
          acc_and = acc_and & p;
        end
      end
      case (mode_q)
        2'd0:    row_res[COL_W'(x)] = acc_or;
        2'd1:    row_res[COL_W'(x)] = acc_and;
        default: row_res[COL_W'(x)] = frame[row][COL_W'(x)];
      endcase
    end
  end

  always_comb begin
    work_nxt      = work;
    work_nxt[row] = row_res;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PROC;
      PROC:    if (last_row && last_pass) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state == PROC);
    bus.done = (state == DONE);
  end

  assign bus.out_image  = out_q;
  assign bus.show_image = show_q;

  // Result registers are loaded on the edge entering DONE so they are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame    <= '0;
      work     <= '0;
      row      <= '0;
      mode_q   <= '0;
      out_q    <= '0;
      show_q   <= '0;
`ifdef IMAGE_MORPH_MULTIPASS_EN
      passes_q <= '0;
      pass_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            frame    <= bus.in_image;
            mode_q   <= bus.mode;
            row      <= '0;
`ifdef IMAGE_MORPH_MULTIPASS_EN
            passes_q <= bus.passes;
            pass_cnt <= '0;
`endif
          end
        end
        PROC: begin
          work <= work_nxt;
          if (last_row) begin
            row <= '0;
            if (last_pass) begin
              show_q <= work_nxt;
              out_q  <= bit_rev(work_nxt);
            end else begin
              frame <= work_nxt;
`ifdef IMAGE_MORPH_MULTIPASS_EN
              pass_cnt <= pass_cnt + 2'd1;
`endif
            end
          end else begin
            row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_image_morph_engine.sv
// Directed self-checking bench for image_morph_engine (32x32, RADIUS=1).
// The multipass scenario is compiled in only with IMAGE_MORPH_MULTIPASS_EN.
module tb_image_morph_engine;
  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
`ifdef IMAGE_MORPH_MULTIPASS_EN
  logic [1:0] tb_passes = 2'd0;
`endif

  always #5 clk = ~clk;

  image_morph_if #(.IMG_W(W), .IMG_H(H)) bus ();

  image_morph_engine #(.IMG_W(W), .IMG_H(H), .RADIUS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[N-1-i] = v[i];
    return r;
  endfunction

  function automatic logic [N-1:0] block(input int x0, input int x1, input int y0, input int y1);
    logic [N-1:0] r;
    r = '0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) r[y*W + x] = 1'b1;
    return r;
  endfunction

  // Starts a run; samples #1 after each edge, cycle 1 being the cycle after acceptance.
  task automatic run(input logic [1:0] m, input logic [N-1:0] img, input int restart_at,
                     input int post, output int done_cyc, output int busy_cnt,
                     output int done_cnt, output logic busy_at_done);
    bus.mode     = m;
    bus.in_image = img;
`ifdef IMAGE_MORPH_MULTIPASS_EN
    bus.passes   = tb_passes;
`endif
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    done_cyc     = -1;
    busy_cnt     = 0;
    done_cnt     = 0;
    busy_at_done = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = bus.busy;
        end
      end
      if (c == restart_at) begin
        bus.start    = 1'b1;
        bus.in_image = '1;
        bus.mode     = 2'd0;
      end else begin
        bus.start = 1'b0;
      end
      if (done_cyc >= 0 && c >= done_cyc + post) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.in_image = '0;
`ifdef IMAGE_MORPH_MULTIPASS_EN
    bus.passes = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests++; if (bus.show_image !== '0) begin fails++; $display("FAIL reset_show: %0d pixels set, want 0", $countones(bus.show_image)); end
    tests++; if (bus.out_image !== '0) begin fails++; $display("FAIL reset_out: %0d pixels set, want 0", $countones(bus.out_image)); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dilate_center;
    int dc, bc, dn; logic bd; logic [N-1:0] img, exp_img;
    img = '0; img[16*W + 16] = 1'b1;
    exp_img = block(15, 17, 15, 17);
    run(2'd0, img, 0, 3, dc, bc, dn, bd);
    tests++; if (bus.show_image !== exp_img) begin fails++; $display("FAIL dil_center_show: %0d pixels differ from required 3x3 block", $countones(bus.show_image ^ exp_img)); end
    tests++; if (bus.out_image !== rev(exp_img)) begin fails++; $display("FAIL dil_center_out: %0d pixels differ from required reversed block", $countones(bus.out_image ^ rev(exp_img))); end
    tests++; if (dc !== 33) begin fails++; $display("FAIL dil_center_latency: done at cycle %0d, want 33", dc); end
    tests++; if (bc !== 32) begin fails++; $display("FAIL dil_center_busy: busy for %0d cycles, want 32", bc); end
    tests++; if (bd !== 1'b0) begin fails++; $display("FAIL dil_center_busy_in_done: got %b want 0", bd); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL dil_center_done_count: got %0d want 1", dn); end
  endtask

  task automatic test_dilate_corner;
    int dc, bc, dn; logic bd; logic [N-1:0] img, exp_img;
    img = '0; img[0] = 1'b1;
    exp_img = block(0, 1, 0, 1);
    run(2'd0, img, 0, 0, dc, bc, dn, bd);
    tests++; if (bus.show_image !== exp_img) begin fails++; $display("FAIL dil_corner_show: %0d pixels differ from required 2x2 corner", $countones(bus.show_image ^ exp_img)); end
    tests++; if (bus.show_image[31*W + 31] !== 1'b0) begin fails++; $display("FAIL dil_corner_wrap_31_31: got %b want 0", bus.show_image[31*W + 31]); end
    tests++; if (bus.show_image[31*W + 0] !== 1'b0) begin fails++; $display("FAIL dil_corner_wrap_0_31: got %b want 0", bus.show_image[31*W]); end
    tests++; if (dc !== 33) begin fails++; $display("FAIL dil_corner_latency: done at cycle %0d, want 33", dc); end
  endtask

  task automatic test_erode;
    int dc, bc, dn; logic bd; logic [N-1:0] exp_img;
    exp_img = '0; exp_img[10*W + 10] = 1'b1;
    run(2'd1, block(9, 11, 9, 11), 0, 0, dc, bc, dn, bd);
    tests++; if (bus.show_image !== exp_img) begin fails++; $display("FAIL erode_block_show: %0d pixels differ from required single pixel", $countones(bus.show_image ^ exp_img)); end
    @(posedge clk); #1;
    run(2'd1, '1, 0, 0, dc, bc, dn, bd);
    exp_img = block(1, 30, 1, 30);
    tests++; if (bus.show_image !== exp_img) begin fails++; $display("FAIL erode_full_show: %0d pixels differ from required 30x30 interior", $countones(bus.show_image ^ exp_img)); end
    tests++; if (bus.out_image !== rev(exp_img)) begin fails++; $display("FAIL erode_full_out: %0d pixels differ from required reversed interior", $countones(bus.out_image ^ rev(exp_img))); end
  endtask

  task automatic test_pass_restart;
    int dc, bc, dn; logic bd; logic [N-1:0] img;
    for (int i = 0; i < N; i += 32) img[i +: 32] = $urandom;
    img[0] = 1'b1; img[N-1] = 1'b1;
    @(posedge clk); #1;
    run(2'd2, img, 5, 4, dc, bc, dn, bd);
    tests++; if (bus.show_image !== img) begin fails++; $display("FAIL pass_show: %0d pixels differ from in_image", $countones(bus.show_image ^ img)); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL pass_restart_done_count: got %0d want 1", dn); end
    tests++; if (bc !== 32) begin fails++; $display("FAIL pass_restart_busy: busy for %0d cycles, want 32", bc); end
  endtask

  task automatic test_reset_midrun;
    int dc, bc, dn, done_seen; logic bd; logic [N-1:0] img;
    img = '0; img[16*W + 16] = 1'b1;
    bus.mode = 2'd0; bus.in_image = img; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    tests++; if (bus.show_image !== '0) begin fails++; $display("FAIL midrst_show: %0d pixels set, want 0", $countones(bus.show_image)); end
    tests++; if (bus.out_image !== '0) begin fails++; $display("FAIL midrst_out: %0d pixels set, want 0", $countones(bus.out_image)); end
    @(posedge clk); #2;
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; done_seen += int'(bus.done); end
    tests++; if (done_seen !== 0) begin fails++; $display("FAIL midrst_no_done: %0d done pulses, want 0", done_seen); end
    run(2'd0, img, 0, 0, dc, bc, dn, bd);
    tests++; if (bus.show_image !== block(15, 17, 15, 17)) begin fails++; $display("FAIL midrst_fresh_show: %0d pixels differ from required 3x3 block", $countones(bus.show_image ^ block(15, 17, 15, 17))); end
    tests++; if (dc !== 33) begin fails++; $display("FAIL midrst_fresh_latency: done at cycle %0d, want 33", dc); end
  endtask

  task automatic test_back_to_back;
    int dc, bc, dn; logic bd; logic [N-1:0] img;
    img = '0; img[5*W + 20] = 1'b1;
    run(2'd0, img, 0, 0, dc, bc, dn, bd);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_start_in_done: busy %b, want 0", bus.busy); end
    img = '0; img[31*W + 31] = 1'b1;
    run(2'd0, img, 0, 0, dc, bc, dn, bd);
    tests++; if (dc !== 33) begin fails++; $display("FAIL b2b_latency: done at cycle %0d, want 33", dc); end
    tests++; if (bus.show_image !== block(30, 31, 30, 31)) begin fails++; $display("FAIL b2b_show: %0d pixels differ from required corner block", $countones(bus.show_image ^ block(30, 31, 30, 31))); end
    @(posedge clk); #1;
  endtask

`ifdef IMAGE_MORPH_MULTIPASS_EN
  task automatic test_multipass;
    int dc, bc, dn; logic bd; logic [N-1:0] img;
    img = '0; img[16*W + 16] = 1'b1;
    tb_passes = 2'd1;
    run(2'd0, img, 0, 2, dc, bc, dn, bd);
    tb_passes = 2'd0;
    tests++; if (bus.show_image !== block(14, 18, 14, 18)) begin fails++; $display("FAIL multipass_show: %0d pixels differ from required 5x5 block", $countones(bus.show_image ^ block(14, 18, 14, 18))); end
    tests++; if (dc !== 65) begin fails++; $display("FAIL multipass_latency: done at cycle %0d, want 65", dc); end
    tests++; if (bc !== 64) begin fails++; $display("FAIL multipass_busy: busy for %0d cycles, want 64", bc); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL multipass_done_count: got %0d want 1", dn); end
  endtask
`endif

  initial begin
    test_reset();
    test_dilate_center();
    @(posedge clk); #1;
    test_dilate_corner();
    @(posedge clk); #1;
    test_erode();
    test_pass_restart();
    test_reset_midrun();
    @(posedge clk); #1;
    test_back_to_back();
`ifdef IMAGE_MORPH_MULTIPASS_EN
    test_multipass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/image_morph_engine.md
Name: image_morph_engine

Overview:
- Sequential, parametrised successor to the combinational 32x32 bitmap dilation stage.
- Takes a full binary frame and applies a square (2*RADIUS+1) morphological kernel: dilation, erosion or pass-through.
- Processes one output row per clock and presents the result frame atomically with a done pulse.
- Sits between the drawing-pad capture logic and the DNN input / VGA display path.

Parameters:
- IMG_W, 32, frame width in pixels
- IMG_H, 32, frame height in pixels
- RADIUS, 1, kernel half-size; kernel is (2*RADIUS+1) x (2*RADIUS+1); legal range 0..3

Ports:
- clk  input  1  system clock, all state rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request processing of in_image; sampled only in IDLE
- mode  input  2  0 = dilate (OR), 1 = erode (AND), 2 = pass-through, 3 = reserved (treated as pass-through)
- in_image  input  IMG_W*IMG_H  source frame; pixel i = y*IMG_W + x
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when out_image/show_image update
- out_image  output  IMG_W*IMG_H  result, bit-reversed: out_image[IMG_W*IMG_H-1-i] = result pixel i
- show_image  output  IMG_W*IMG_H  result, natural order: show_image[i] = result pixel i

Behaviour:
- Reset: state IDLE; busy=0, done=0, out_image=0, show_image=0, frame/work buffers=0, row counter=0.
- States: IDLE, PROC, DONE.
- IDLE: on start=1, latch in_image into frame buffer, latch mode, row=0, go to PROC. start=0: stay.
- PROC, one row per cycle: compute result row r into work buffer; r==IMG_H-1 -> DONE, else r+1.
  - Dilate: result(x,y) = OR of frame(x+dx, y+dy), |dx|,|dy| <= RADIUS.
  - Erode: result(x,y) = AND over the same window.
  - Pass: result = frame.
- Borders: out-of-frame neighbours read as 0 in both dilate and erode. No wrap-around. Consequence: erosion clears every pixel within RADIUS of an edge.
- DONE: copy work buffer to out_image/show_image, done=1 for this one cycle, then IDLE.
- Latency: start accepted at edge N; busy high N+1 .. N+IMG_H; done high at cycle N+IMG_H+1; outputs valid from that same cycle.
- busy is low in the DONE cycle.
- Outputs hold their last value until the next DONE.
- start while in PROC or DONE: ignored, not queued. start high in IDLE in the cycle after DONE: accepted.
- Changes to in_image or mode after acceptance have no effect on the current run.
- RADIUS=0: dilate and erode both equal pass-through.
- Reset mid-run: abort immediately. Outputs clear to 0, no done pulse.

Optional Feature:
- Macro: IMAGE_MORPH_MULTIPASS_EN
- Enabled:
  - Extra input port passes (2 bits); the value is latched at start, effective pass count = passes+1 (1..4).
  - At the end of each non-final pass, the work buffer is copied into the frame buffer and row resets to 0; the block stays in PROC.
  - busy stays high throughout all passes. done fires once, after the last pass, at cycle N + (passes+1)*IMG_H + 1.
- Disabled: port absent; exactly one pass.

Test Plan:
- Dilate, R=1, single pixel (16,16) -> show_image has 3x3 block x,y in 15..17; done at cycle 33 after start; out_image equals show_image bit-reversed.
- Dilate, R=1, pixel (0,0) -> only pixels (0,0),(1,0),(0,1),(1,1) set. Bench checks no wrap: pixel (31,31) and pixel (0,31) stay 0.
- Erode, R=1, 3x3 block centred (10,10) -> only (10,10) set. Erode of an all-ones frame -> 30x30 interior set, 1-pixel border clear.
- Mode 2 with a random frame -> show_image equals in_image. A second start pulsed at cycle 5 of a run is ignored: exactly one done, and busy count is 32.
- Reset asserted at cycle 10 of a run -> busy=0, outputs 0, no done. A fresh start afterwards completes normally.
- IMAGE_MORPH_MULTIPASS_EN, passes=1, dilate R=1, pixel (16,16) -> 5x5 block x,y in 14..18; done at cycle 65.
